// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: memory-mapped HUB75 row scan sequencer.
// Double-buffered line memory feeding a shift/latch/display FSM.
module hub75_scan_ctrl #(
  parameter int          WIDTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic [5:0]  hub_rgb,
  output logic [4:0]  hub_row,
  output logic        hub_clk,
  output logic        hub_stb,
  output logic        hub_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [9:0] LINE_LO = 10'h040;
  localparam logic [9:0] LINE_HI = 10'(64 + WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t state, state_n;

  logic [CW-1:0] col, col_n, col_inc;
  logic          hi, hi_n;
  logic [7:0]    cnt, cnt_n;
  logic [1:0]    lcnt, lcnt_n;
  logic [15:0]   dcnt, dcnt_n;
  logic [5:0]    rgb_n;
  logic [4:0]    row_n, row_next, back_row;
  logic          front_sel, back_full, swap;
  logic          en;
  logic [7:0]    div;
  logic [15:0]   ontime;
  logic [31:0]   rd_val;
  logic [9:0]    word, line_idx;
  logic [CW-1:0] line_col;
  logic          wr, line_hit, busy, free;
  logic [5:0]    first_px, next_px;
  logic          unused_ok;

  logic [5:0] buf_a [WIDTH];
  logic [5:0] buf_b [WIDTH];

  assign active   = (addr >= BASE_ADDR) &&
                    (addr < BASE_ADDR + 32'h1000);
  assign word     = addr[11:2] - BASE_ADDR[11:2];
  assign wr       = wen & active & (|wmask);
  assign line_hit = (word >= LINE_LO) && (word < LINE_HI);
  assign line_idx = word - LINE_LO;
  assign line_col = line_idx[CW-1:0];
  assign unused_ok = ^{addr[1:0], wdata[31:16], line_idx};

  assign busy    = (state != IDLE);
  assign free    = !back_full;
  assign hub_clk = (state == SHIFT) && hi;
  assign hub_stb = (state == LATCH) && (lcnt == 2'd1);
  assign hub_oe  = (state != DISPLAY);

  // front_sel=0: buf_a scans, buf_b is the back buffer
  assign col_inc  = col + CW'(1);
  assign first_px = front_sel ? buf_a[0] : buf_b[0];
  assign next_px  = front_sel ? buf_b[col_inc] : buf_a[col_inc];

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      word == 10'h000: rd_val = {16'h0, div, 7'h0, en};
      word == 10'h001: rd_val = {16'h0, ontime};
      word == 10'h002: rd_val = {19'h0, hub_row, 6'h0, busy, free};
      default:         rd_val = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    hi_n    = hi;
    cnt_n   = cnt;
    lcnt_n  = lcnt;
    dcnt_n  = dcnt;
    rgb_n   = hub_rgb;
    row_n   = hub_row;
    swap    = 1'b0;
    if (!en && state != IDLE) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && back_full) begin
            swap    = 1'b1;
            state_n = SHIFT;
            col_n   = '0;
            hi_n    = 1'b0;
            cnt_n   = '0;
            rgb_n   = first_px;
          end
        end
        SHIFT: begin
          if (cnt != div) begin
            cnt_n = cnt + 8'd1;
          end else begin
            cnt_n = '0;
            if (!hi) begin
              hi_n = 1'b1;
            end else if (col == COL_LAST) begin
              hi_n    = 1'b0;
              lcnt_n  = '0;
              state_n = LATCH;
            end else begin
              hi_n  = 1'b0;
              col_n = col_inc;
              rgb_n = next_px;
            end
          end
        end
        LATCH: begin
          lcnt_n = lcnt + 2'd1;
          if (lcnt == 2'd0) row_n = row_next;
          if (lcnt == 2'd2) begin
            dcnt_n  = '0;
            state_n = (ontime == 16'd0) ? IDLE : DISPLAY;
          end
        end
        DISPLAY: begin
          dcnt_n = dcnt + 16'd1;
          if ((dcnt + 16'd1) >= ontime) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      hi        <= 1'b0;
      cnt       <= '0;
      lcnt      <= '0;
      dcnt      <= '0;
      hub_rgb   <= '0;
      hub_row   <= '0;
      row_next  <= '0;
      back_row  <= '0;
      front_sel <= 1'b0;
      back_full <= 1'b0;
      en        <= 1'b0;
      div       <= '0;
      ontime    <= 16'h0100;
      ready     <= 1'b0;
      rdata     <= '0;
    end else begin
      state   <= state_n;
      col     <= col_n;
      hi      <= hi_n;
      cnt     <= cnt_n;
      lcnt    <= lcnt_n;
      dcnt    <= dcnt_n;
      hub_rgb <= rgb_n;
      hub_row <= row_n;
      ready   <= (ren | wen) & active;
      rdata   <= (ren & active) ? rd_val : '0;
      if (wr && word == 10'h000) begin
        en  <= wdata[0];
        div <= wdata[15:8];
      end
      if (wr && word == 10'h001) ontime <= wdata[15:0];
      // a swap in the same cycle wins over a COMMIT
      if (swap) begin
        front_sel <= ~front_sel;
        row_next  <= back_row;
        back_full <= 1'b0;
      end else if (wr && word == 10'h003 && !back_full) begin
        back_row  <= wdata[4:0];
        back_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && line_hit && !back_full) begin
      if (front_sel) buf_a[line_col] <= wdata[5:0];
      else           buf_b[line_col] <= wdata[5:0];
    end
  end

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Hardware scan sequencer for a HUB75 LED panel, attached to the SoC bus hub as a memory-mapped device. It replaces software bit-banging of the HUB75 pins through the parallel output port. Software fills a double-buffered line memory and commits it with a target row. The block then shifts the row out, latches it, drives the row address and holds OE for a programmable on-time, without CPU involvement.

## Interface
- `WIDTH`, 64: panel columns, i.e. pixels shifted per row.
- `BASE_ADDR`, 32'h0001_0000: byte base of the 4 KiB register window.
- `clk`  in  1: core clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `addr`  in  32: bus byte address.
- `wdata`  in  32: bus write data.
- `wmask`  in  4: byte write mask. Any nonzero mask writes the addressed register.
- `ren`  in  1: bus read request.
- `wen`  in  1: bus write request.
- `rdata`  out  32: read data. Zero when not active.
- `ready`  out  1: access complete.
- `active`  out  1: combinational, `addr` is within [BASE_ADDR, BASE_ADDR+0x1000).
- `hub_rgb`  out  6: {B1,B0,G1,G0,R1,R0}.
- `hub_row`  out  5: row address {E,D,C,B,A}.
- `hub_clk`  out  1: shift clock.
- `hub_stb`  out  1: latch strobe.
- `hub_oe`  out  1: output enable, active-low (1 = blank).

## Operation
Register map, byte offsets from BASE_ADDR:
- 0x000 CTRL, RW, reset 0.
  - bit0 `en`.
  - [15:8] `div`: shift-clock half-period is div+1 cycles.
- 0x004 ONTIME, RW, reset 0x0100. [15:0] is the OE-low cycle count per row.
- 0x008 STATUS, RO.
  - bit0 `free`, which is !back_full.
  - bit1 `busy`, which is state != IDLE.
  - [12:8] row currently displayed.
- 0x00C COMMIT, WO. If !back_full: back_row <= wdata[4:0], back_full <= 1. If back_full is already 1, the write is ignored.
- 0x100 + 4*c, for c < WIDTH: LINE[c], WO. wdata[5:0] is written into the back buffer only when !back_full; otherwise ignored.
- Reads of write-only or unmapped offsets return 0.

Buffers:
- Two WIDTH×6 line buffers. A `front_sel` bit chooses the scanning buffer; the other is the back buffer.

State machine IDLE → SHIFT → LATCH → DISPLAY → IDLE:
- **IDLE**: outputs are hub_clk=0, hub_stb=0, hub_oe=1. If en && back_full: toggle front_sel, row_next <= back_row, clear back_full, go to SHIFT.
- **SHIFT**: column counter runs 0..WIDTH-1.
  - Per column, hub_rgb = front[c] and hub_clk=0 for div+1 cycles, then hub_clk=1 for div+1 cycles.
  - After the last column's high phase, go to LATCH with hub_clk=0. hub_oe stays 1.
- **LATCH**: exactly 3 cycles.
  - Cycle 0: hub_row <= row_next.
  - Cycle 1: hub_stb=1.
  - Cycle 2: hub_stb=0.
- **DISPLAY**: hub_oe=0 for ONTIME cycles, then IDLE. If ONTIME=0, go directly to IDLE with no OE pulse.
- **en=0 in any non-IDLE state**: go to IDLE at the next edge. back_full, the buffers and hub_row are preserved.
- The last shifted hub_rgb value is held in IDLE.
- A COMMIT in the same cycle IDLE consumes back_full: the swap takes priority and the COMMIT sees back_full=1, so it is ignored.

## Timing
- Reset values:
  - hub_rgb=0, hub_row=0, hub_clk=0, hub_stb=0, hub_oe=1.
  - rdata=0, ready=0.
  - back_full=0, front_sel=0, state IDLE.
  - Buffer contents are undefined.
- Asserting rst_n low mid-row immediately forces these values asynchronously.
- Bus: ready is registered, `ready <= (ren|wen) & active`, so it is high exactly one cycle after the request.
  - rdata is valid in the same cycle as ready.
  - Writes take effect at the request edge.
- Row period from the swap edge: 1 + WIDTH·2·(div+1) + 3 + ONTIME cycles.
- The new hub_rgb value appears on the same edge that hub_clk falls. Data is therefore stable for div+1 cycles before the rising edge.
- `free` rises the cycle after the swap, so software can fill the next line during SHIFT/DISPLAY.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0.
  - Required: hub_oe=1, all other HUB75 outputs 0, ready=0; after release, STATUS reads 0x1 and ONTIME reads 0x100.
- Single row, WIDTH=4, div=0, ONTIME=5:
  - Stimulus: write LINE = 0x01, 0x02, 0x04, 0x08, COMMIT 0x03, CTRL=1.
  - Required: 4 hub_clk pulses, each 1 cycle high, with hub_rgb matching the line data at each rising edge. Then hub_row=3, one hub_stb pulse, hub_oe low for exactly 5 cycles. Total 1+8+3+5=17 cycles.
- Back-to-back double buffering:
  - Stimulus: commit row 0, then immediately fill and commit row 1 while row 0 is displaying.
  - Required: row 1 starts the cycle after DISPLAY ends. A third COMMIT issued while back_full=1 is ignored, and row 1 data is unchanged.
- div=3:
  - Required: each hub_clk phase is 4 cycles and hub_rgb changes only on falling edges.
- ONTIME=0:
  - Required: hub_oe never goes low and the FSM returns to IDLE after LATCH.
- Enable and reset mid-row:
  - Stimulus: clear en mid-SHIFT.
  - Required: next cycle hub_clk=0 and hub_oe=1, STATUS.busy=0, and back_full is unchanged.
  - Stimulus: assert rst_n low mid-DISPLAY.
  - Required: hub_oe=1 with no clock edge needed.
